branch_resolver: RTL and testbench
==================================

# branch_resolver

Resolution end of the branch prediction path: records every prediction issued to FETCH in an in-order in-flight queue, compares it in EXEC against the actual branch outcome, and on mismatch issues a one-cycle redirect and flushes wrong-path entries. It also drives the training interface (PC, taken, target) back toward the predictor and keeps saturating branch and mispredict counters for performance debug.

## Interface
- DEPTH, 4: in-flight prediction queue entries, power of two, 2..16.
- CNT_W, 16: width of the statistics counters.
- clk in 1: single clock, all state on rising edge.
- rst_n in 1: synchronous, active-low reset.
- f_valid in 1: an instruction is accepted by FETCH this cycle (push).
- f_pc in 32: PC of that instruction.
- f_predict_valid in 1: predictor said taken for f_pc.
- f_predict_addr in 32: predicted target; ignored when f_predict_valid=0.
- x_valid in 1: the oldest in-flight instruction resolves in EXEC this cycle (pop).
- x_pc in 32: PC of the resolving instruction.
- x_is_branch in 1: resolving instruction is a branch.
- x_taken in 1: branch actually taken; ignored when x_is_branch=0.
- x_target in 32: actual branch target.
- redirect_valid out 1: one-cycle pulse; FETCH must restart at redirect_addr.
- redirect_addr out 32: correct next PC.
- upd_valid out 1: one-cycle training pulse for each resolved branch.
- upd_pc out 32, upd_taken out 1, upd_target out 32: training data.
- q_full out 1, q_empty out 1: queue status, combinational from count.
- branch_count out CNT_W, mispredict_count out CNT_W: saturating statistics.
- err_overflow out 1, err_sync out 1: sticky error flags.

## Operation
- Queue entry: {pc, pred_taken, pred_addr}; circular buffer, log2(DEPTH)-bit read/write pointers plus (log2(DEPTH)+1)-bit count; pointers wrap from DEPTH-1 to 0.
- Push when f_valid and state RUN; pop when x_valid. Simultaneous push and pop permitted when full (count unchanged) and when empty (push only; the pop is handled as below).
- Push when full and no pop: dropped, err_overflow set.
- Pop when empty: resolved against pred_taken=0, err_sync set.
- Head pc != x_pc: err_sync set, compare proceeds using head prediction.
- Correct next PC: x_is_branch and x_taken ? x_target : x_pc+4 (modulo 2^32).
- Predicted next PC: pred_taken ? pred_addr : pc+4 (using head entry pc).
- Mispredict when the two differ (covers wrong direction, wrong target, and a taken prediction on a non-branch).
- Mispredict: redirect_valid=1, redirect_addr = correct next PC, queue cleared (count=0, pointers 0), any push in that cycle discarded, state -> RECOVER.
- State RUN: normal. State RECOVER: exactly one cycle, all pushes discarded (wrong-path fetch still in flight), pops still processed; then -> RUN.
- Each pop with x_is_branch=1: upd_valid=1, upd_pc=x_pc, upd_taken=x_taken, upd_target=x_target, branch_count+1. Mispredict additionally increments mispredict_count. Counters stick at all-ones.

## Timing
- All outputs except q_full/q_empty are registered: redirect and update appear on the cycle after x_valid is sampled.
- Pushed entry is poppable on the next cycle.
- Reset (any cycle, including mid-redirect): queue empty, state RUN, redirect_valid=0, redirect_addr=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0, counters 0, error flags 0; q_empty=1, q_full=0. Reset dominates all inputs that cycle.
- Back-to-back mispredicts: second resolves against the empty queue (err_sync) only if x_valid arrives; pipeline must not pop wrong-path instructions.

## Structure
- Shared package branch_pkg: pred_entry_t struct {pc, pred_taken, pred_addr}, resolver state enum {RUN, RECOVER}, constant INSTR_BYTES=4.
- One sub-module: pred_fifo (parameterised circular buffer with push, pop, clear, full, empty, count); comparison, FSM and counters stay in branch_resolver.

## Test plan
- Push pc 0x100 pred not-taken; pop x_pc 0x100, is_branch=0 -> no redirect, no upd_valid, counters 0.
- Push 0x200 pred taken 0x400; pop branch taken 0x400 -> upd_valid with (0x200,1,0x400), branch_count=1, no redirect.
- Push 0x200 pred taken 0x400, push 0x204; pop branch not-taken -> redirect to 0x204, mispredict_count=1, q_empty=1 next cycle, push during redirect and RECOVER cycles dropped.
- Push 0x300 pred taken 0x500; pop branch taken 0x600 -> redirect to 0x600 (target mismatch).
- Push DEPTH+1 entries without pops -> q_full after DEPTH, err_overflow=1; then simultaneous push/pop at full keeps count=DEPTH, FIFO order preserved across pointer wrap.
- Assert rst_n=0 in the same cycle as a mispredicting pop -> next cycle redirect_valid=0, queue empty, all counters and flags 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch resolution path: in-flight prediction entry,
// resolver state and instruction size.
package branch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } res_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_addr;
  } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order circular buffer of predictions; an entry pushed this cycle is readable next cycle.
// A push is dropped when full unless a pop frees a slot in the same cycle; pops on empty are ignored.
module pred_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  pred_entry_t wdata_i,
  input  logic        pop_i,
  input  logic        clear_i,
  output pred_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  pred_entry_t   mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0 naturally.
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push) wptr_d = wptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolver.sv
// Compares each resolving instruction against its recorded prediction; redirect, training and stats
// are registered one cycle after x_valid. FETCH is not back-pressured: overflowing pushes are dropped and flagged.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid,
  input  logic [31:0]      f_pc,
  input  logic             f_predict_valid,
  input  logic [31:0]      f_predict_addr,
  input  logic             x_valid,
  input  logic [31:0]      x_pc,
  input  logic             x_is_branch,
  input  logic             x_taken,
  input  logic [31:0]      x_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_addr,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic             q_full,
  output logic             q_empty,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             err_overflow,
  output logic             err_sync
);

  localparam int AW = $clog2(DEPTH);

  res_state_e  state_q, state_d;
  pred_entry_t wr_entry, head;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        push_req, mispredict, head_taken;
  logic [31:0] head_pc, pred_next, correct_next;

  logic             redir_vld_q, redir_vld_d, upd_vld_q, upd_vld_d;
  logic [31:0]      redir_addr_q, redir_addr_d, upd_pc_q, upd_pc_d, upd_tgt_q, upd_tgt_d;
  logic             upd_taken_q, upd_taken_d, err_ovf_q, err_ovf_d, err_sync_q, err_sync_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  // An empty queue resolves as a not-taken prediction at the resolving PC itself.
  assign head_pc      = fifo_empty ? x_pc : head.pc;
  assign head_taken   = !fifo_empty && head.pred_taken;
  assign pred_next    = head_taken ? head.pred_addr : head_pc + INSTR_BYTES;
  assign correct_next = (x_is_branch && x_taken) ? x_target : x_pc + INSTR_BYTES;
  assign mispredict   = x_valid && (pred_next != correct_next);
  assign push_req     = f_valid && (state_q == RUN) && !mispredict;

  assign wr_entry = '{pc: f_pc, pred_taken: f_predict_valid,
                      pred_addr: f_predict_valid ? f_predict_addr : 32'd0};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .wdata_i (wr_entry),
    .pop_i   (x_valid),
    .clear_i (mispredict),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d      = mispredict ? RECOVER : RUN;
    redir_vld_d  = mispredict;
    redir_addr_d = mispredict ? correct_next : redir_addr_q;
    upd_vld_d    = x_valid && x_is_branch;
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;
    upd_tgt_d    = upd_tgt_q;
    br_cnt_d     = br_cnt_q;
    mp_cnt_d     = mp_cnt_q;
    err_ovf_d    = err_ovf_q || (push_req && fifo_full && !x_valid);
    err_sync_d   = err_sync_q || (x_valid && (fifo_empty || head.pc != x_pc));
    if (x_valid && x_is_branch) begin
      upd_pc_d    = x_pc;
      upd_taken_d = x_taken;
      upd_tgt_d   = x_target;
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
      if (mispredict && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      redir_vld_q  <= 1'b0;
      redir_addr_q <= '0;
      upd_vld_q    <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_tgt_q    <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
      err_ovf_q    <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_vld_q  <= redir_vld_d;
      redir_addr_q <= redir_addr_d;
      upd_vld_q    <= upd_vld_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      upd_tgt_q    <= upd_tgt_d;
      br_cnt_q     <= br_cnt_d;
      mp_cnt_q     <= mp_cnt_d;
      err_ovf_q    <= err_ovf_d;
      err_sync_q   <= err_sync_d;
    end
  end

  assign redirect_valid   = redir_vld_q;
  assign redirect_addr    = redir_addr_q;
  assign upd_valid        = upd_vld_q;
  assign upd_pc           = upd_pc_q;
  assign upd_taken        = upd_taken_q;
  assign upd_target       = upd_tgt_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;
  assign err_overflow     = err_ovf_q;
  assign err_sync         = err_sync_q;
  assign q_full           = fifo_full;
  assign q_empty          = (fifo_count == '0);

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboarded bench: a queue-based reference model predicts redirects, training pulses and status,
// and an independent negedge monitor compares them as the DUT presents them.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk, rst_n;
  logic             f_valid, f_predict_valid, x_valid, x_is_branch, x_taken;
  logic [31:0]      f_pc, f_predict_addr, x_pc, x_target;
  logic             redirect_valid, upd_valid, upd_taken, q_full, q_empty, err_overflow, err_sync;
  logic [31:0]      redirect_addr, upd_pc, upd_target;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_pc(f_pc), .f_predict_valid(f_predict_valid), .f_predict_addr(f_predict_addr),
    .x_valid(x_valid), .x_pc(x_pc), .x_is_branch(x_is_branch), .x_taken(x_taken), .x_target(x_target),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .q_full(q_full), .q_empty(q_empty),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .err_overflow(err_overflow), .err_sync(err_sync)
  );

  typedef struct { logic [31:0] pc; logic pt; logic [31:0] pa; } ment_t;
  typedef struct { int tag; logic [31:0] a; logic [31:0] b; logic t; } ev_t;
  typedef struct { int tag; logic full; logic empty; logic eov; logic esy; int bc; int mc; } st_t;

  ment_t mq[$];
  ev_t   er[$], eu[$];
  st_t   es[$];
  int    bc, mc, cyc, n_chk, n_fail;
  logic  eov, esy, recover;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v == SAT) ? v : v + 1;
  endfunction

  // Drive one cycle of inputs and advance the model to the state after the edge that samples them.
  task automatic step(input logic rst, input logic fv, input logic [31:0] fpc, input logic fpt,
                      input logic [31:0] fpa, input logic xv, input logic [31:0] xpc,
                      input logic xb, input logic xt, input logic [31:0] xtg);
    logic [31:0] hpc, hpa, cor, prd;
    logic        hpt, mis;
    ment_t       h;
    ev_t         e;
    st_t         s;
    @(posedge clk); #1;
    rst_n = !rst; f_valid = fv; f_pc = fpc; f_predict_valid = fpt; f_predict_addr = fpa;
    x_valid = xv; x_pc = xpc; x_is_branch = xb; x_taken = xt; x_target = xtg;
    if (rst) begin
      mq.delete(); recover = 1'b0; bc = 0; mc = 0; eov = 1'b0; esy = 1'b0;
    end else begin
      mis = 1'b0;
      if (xv) begin
        if (mq.size() == 0) begin
          hpc = xpc; hpt = 1'b0; hpa = 32'd0; esy = 1'b1;
        end else begin
          h = mq.pop_front();
          hpc = h.pc; hpt = h.pt; hpa = h.pa;
          if (hpc != xpc) esy = 1'b1;
        end
        cor = (xb && xt) ? xtg : xpc + 32'd4;
        prd = hpt ? hpa : hpc + 32'd4;
        mis = (cor != prd);
        if (xb) begin
          bc = sat(bc);
          if (mis) mc = sat(mc);
          e = '{cyc + 1, xpc, xtg, xt};
          eu.push_back(e);
        end
        if (mis) begin
          e = '{cyc + 1, cor, 32'd0, 1'b0};
          er.push_back(e);
        end
      end
      if (fv && !recover && !mis) begin
        if (mq.size() < DEPTH) begin
          h = '{fpc, fpt, fpa};
          mq.push_back(h);
        end else eov = 1'b1;
      end
      if (mis) mq.delete();
      recover = mis;
    end
    s = '{cyc + 1, mq.size() == DEPTH, mq.size() == 0, eov, esy, bc, mc};
    es.push_back(s);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest matching expectation.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      if (es.size() > 0 && es[0].tag == cyc) begin
        st_t s;
        s = es.pop_front();
        chk("status", 96'({q_full, q_empty, err_overflow, err_sync, branch_count, mispredict_count}),
            96'({s.full, s.empty, s.eov, s.esy, CNT_W'(s.bc), CNT_W'(s.mc)}));
      end
      while (er.size() > 0 && er[0].tag < cyc) begin
        chk("redirect_missing", 96'(redirect_valid), 96'(1));
        void'(er.pop_front());
      end
      while (eu.size() > 0 && eu[0].tag < cyc) begin
        chk("upd_missing", 96'(upd_valid), 96'(1));
        void'(eu.pop_front());
      end
      if (redirect_valid) begin
        if (er.size() == 0 || er[0].tag != cyc) chk("redirect_unexpected", 96'(redirect_valid), 96'(0));
        else begin
          ev_t e;
          e = er.pop_front();
          chk("redirect_addr", 96'(redirect_addr), 96'(e.a));
        end
      end
      if (upd_valid) begin
        if (eu.size() == 0 || eu[0].tag != cyc) chk("upd_unexpected", 96'(upd_valid), 96'(0));
        else begin
          ev_t e;
          e = eu.pop_front();
          chk("upd_data", 96'({upd_pc, upd_target, upd_taken}), 96'({e.a, e.b, e.t}));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fpc, fpa, xpc, xtg;
    cyc = 0; n_chk = 0; n_fail = 0;
    bc = 0; mc = 0; eov = 1'b0; esy = 1'b0; recover = 1'b0;
    rst_n = 1'b0; f_valid = 1'b0; f_pc = '0; f_predict_valid = 1'b0; f_predict_addr = '0;
    x_valid = 1'b0; x_pc = '0; x_is_branch = 1'b0; x_taken = 1'b0; x_target = '0;

    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    chk("reset_outputs", 96'({redirect_valid, upd_valid, q_empty, q_full, redirect_addr}), 96'({4'b0010, 32'd0}));

    // Non-branch, correctly predicted fall-through.
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    chk("nonbranch", 96'({redirect_valid, upd_valid, branch_count, mispredict_count}), 96'(0));

    // Correctly predicted taken branch trains the predictor.
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h400);
    idle();
    @(negedge clk);
    chk("taken_ok", 96'({redirect_valid, upd_valid, upd_pc, upd_taken, upd_target, branch_count}),
        96'({1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 4'd1}));

    // Direction mispredict flushes younger entry; pushes at mispredict and in RECOVER dropped.
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h204, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h208, 1'b0, 32'd0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h400);
    step(1'b0, 1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("dir_mispredict", 96'({redirect_valid, redirect_addr, mispredict_count, q_empty}),
        96'({1'b1, 32'h204, 4'd1, 1'b1}));
    idle();
    @(negedge clk);
    chk("recover_drop", 96'({q_empty, redirect_valid}), 96'({1'b1, 1'b0}));

    // Target mispredict.
    step(1'b0, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h600);
    idle();
    @(negedge clk);
    chk("tgt_mispredict", 96'({redirect_valid, redirect_addr}), 96'({1'b1, 32'h600}));
    idle();

    // Fill past capacity, then stream push+pop at full across the pointer wrap, then drain.
    for (int i = 0; i <= DEPTH; i++)
      step(1'b0, 1'b1, 32'h1000 + 32'(i * 4), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    chk("overflow", 96'({q_full, err_overflow}), 96'(2'b11));
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 32'h2000 + 32'(i * 4), 1'b0, 32'd0, 1'b1, mq[0].pc, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("full_stream", 96'({q_full, redirect_valid}), 96'(2'b10));
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mq[0].pc, 1'b0, 1'b0, 32'd0);
    idle();

    // Reset coincident with a mispredicting pop.
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h200, 1'b1, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    chk("reset_mispredict", 96'({redirect_valid, redirect_addr, upd_valid, upd_pc, upd_taken,
                                 branch_count, mispredict_count, err_overflow, err_sync, q_empty}),
        96'({1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}));
    chk("reset_upd_target", 96'(upd_target), 96'(0));

    // Randomized traffic including empty pops, sync errors, overflow and counter saturation.
    for (int i = 0; i < 600; i++) begin
      fpc = 32'($urandom_range(0, 255)) << 2;
      fpa = 32'($urandom_range(0, 255)) << 2;
      xpc = (mq.size() > 0 && $urandom_range(0, 9) != 0) ? mq[0].pc : 32'($urandom_range(0, 255)) << 2;
      xtg = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].pa : 32'($urandom_range(0, 255)) << 2;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, fpc, 1'($urandom_range(0, 1)), fpa,
           $urandom_range(0, 9) < 4, xpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), xtg);
    end
    idle();
    idle();
    idle();
    @(negedge clk);
    chk("scoreboard_drained", 96'({16'(er.size()), 16'(eu.size())}), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
